hs32_decode: RTL and testbench
==============================

Name: hs32_decode

Overview:
- Decode stage directly upstream of hs32_alu.
- Accepts 32-bit instruction words from fetch over a valid/ready handshake.
- Splits each word into ALU operator, register indices and immediates, and presents them to execute through a registered valid/ready output.
- Contains a 2-entry skid buffer, so execute back-pressure never creates a combinational ready path back to fetch.

Parameters:
- (none)

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- flush  input  1  synchronous pipeline flush (branch/exception)
- in_valid  input  1  fetch presents an instruction
- in_ready  output  1  decode can accept an instruction this cycle
- in_instr  input  32  instruction word
- out_valid  output  1  decoded bundle valid
- out_ready  input  1  execute consumes bundle this cycle
- aluop  output  3  ALU operation
- rd  output  4  destination register
- rm  output  4  first source register
- rn  output  4  second source register
- imm16  output  16  16-bit immediate
- imm5  output  16  5-bit shift amount, zero-extended to 16
- use_imm  output  1  operand B taken from imm16 (1) or rn (0)
- use_shamt  output  1  operand B taken from imm5
- reg_we  output  1  result written to rd
- fault  output  1  illegal opcode (only with HS32_DEC_FAULT_EN)

Behaviour:
Encoding:
- major = in_instr[31:28]; aluop = in_instr[27:25]; in_instr[24] reserved, ignored.
- rd = [23:20], rm = [19:16], rn = [15:12], imm16 = [15:0], imm5 = {11'b0, [11:7]}.

Major decode:
- 0x0 NOP: aluop=0, reg_we=0, use_imm=0, use_shamt=0.
- 0x1 reg-reg: reg_we=1, use_imm=0, use_shamt=0.
- 0x2 reg-imm16: reg_we=1, use_imm=1, use_shamt=0.
- 0x3 reg-shift: reg_we=1, use_imm=0, use_shamt=1.
- 0x4–0xF illegal; handling defined under Optional Feature.
- Field outputs are always the raw slices, whatever the major.

Skid buffer:
- Output register (OR) drives all out_* fields; skid register (SR) holds one extra decoded bundle.
- States: EMPTY (OR and SR empty), ONE (OR full), TWO (OR and SR full).
- in_ready = (state != TWO), registered. out_valid = (state != EMPTY).
- Transfer in = in_valid & in_ready. Transfer out = out_valid & out_ready.
- EMPTY: in → OR, go to ONE.
- ONE, in only: in → SR, go to TWO.
- ONE, out only: go to EMPTY.
- ONE, in and out: in → OR, stay ONE.
- TWO, out: SR → OR, go to ONE. in_ready is 0 in TWO, so no input transfer.
- Latency: accepted instruction appears on out_* the next cycle when OR is free.
- Ordering strictly FIFO. Bundles are never dropped or duplicated.
- OR holds its value while out_valid & !out_ready.

Flush and reset:
- flush=1: state → EMPTY next cycle, OR/SR contents discarded, in_ready=1 next cycle.
- Any input handshaking in a flush cycle is discarded (flush wins).
- reset overrides flush, and reset mid-transfer discards all in-flight words.
- Reset values: state=EMPTY, out_valid=0, in_ready=1, all field and control outputs 0, fault=0.

Optional Feature:
- Macro: HS32_DEC_FAULT_EN.
- Defined:
  - An illegal major sets fault=1 in its bundle, with reg_we=0, use_imm=0, use_shamt=0.
  - The bundle still flows through the handshake; fault is carried through SR like any other field.
- Undefined:
  - The fault port is tied to 0.
  - An illegal major decodes exactly as NOP (aluop=0, reg_we=0).

Test Plan:
- Reset, then in_instr=0x2A3_1_1234 (major 2, aluop 5, rd 3, rm 1), in_valid=1, out_ready=1 → next cycle out_valid=1, aluop=5, rd=3, rm=1, imm16=0x1234, use_imm=1, reg_we=1.
- Shift word 0x3_4_5_6_0_380 → aluop=2, rd=5, rm=6, imm5=0x0007, use_shamt=1.
- out_ready=0, push A, B, C back-to-back → A on outputs, in_ready=0 after B accepted, C held. Release out_ready → A, B, C emerge in order, one per cycle, none lost.
- Continuous in_valid=1 and out_ready=1 for 16 words → 1 word/cycle throughput, in_ready never 0.
- State TWO, assert flush with in_valid=1 → next cycle out_valid=0, in_ready=1; flushed-cycle word never appears.
- in_instr=0xF0000000: with HS32_DEC_FAULT_EN → fault=1, reg_we=0; without → fault=0, aluop=0, reg_we=0.

Source files
------------

// File: rtl/hs32_decode.sv
// hs32_decode: decode stage between fetch and hs32_alu.
//   Latency: an accepted word appears on the out_* fields on the next cycle when
//   the output register is free. Backpressure: a 2-entry skid buffer means
//   in_ready depends only on registered state, never combinationally on out_ready.
// Optional feature macro: HS32_DEC_FAULT_EN (illegal majors raise fault instead
//   of decoding as NOP).
// Ports:
//   clk, reset (sync, active-high), flush (sync pipeline flush)
//   in_valid / in_ready / in_instr        : fetch-side handshake and word
//   out_valid / out_ready                 : execute-side handshake
//   aluop, rd, rm, rn, imm16, imm5        : decoded fields (raw slices)
//   use_imm, use_shamt, reg_we, fault     : decoded controls
module hs32_decode (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [2:0]  aluop,
  output logic [3:0]  rd,
  output logic [3:0]  rm,
  output logic [3:0]  rn,
  output logic [15:0] imm16,
  output logic [15:0] imm5,
  output logic        use_imm,
  output logic        use_shamt,
  output logic        reg_we,
  output logic        fault
);

  typedef struct packed {
    logic [2:0]  aluop;
    logic [3:0]  rd;
    logic [3:0]  rm;
    logic [3:0]  rn;
    logic [15:0] imm16;
    logic [15:0] imm5;
    logic        use_imm;
    logic        use_shamt;
    logic        reg_we;
    logic        fault;
  } bundle_t;

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

  state_t  state_q, state_d;
  bundle_t or_q, or_d;   // output register, drives out_*
  bundle_t sr_q, sr_d;   // skid register, one extra bundle
  bundle_t dec;

  logic xfer_in, xfer_out;

  // Bit 24 is reserved and intentionally ignored.
  logic unused_rsvd;
  assign unused_rsvd = in_instr[24];

  // Combinational decode of the incoming word.
  always_comb begin
    dec           = '0;
    dec.aluop     = in_instr[27:25];
    dec.rd        = in_instr[23:20];
    dec.rm        = in_instr[19:16];
    dec.rn        = in_instr[15:12];
    dec.imm16     = in_instr[15:0];
    dec.imm5      = {11'b0, in_instr[11:7]};
    case (in_instr[31:28])
      4'h0: dec.aluop = 3'd0;
      4'h1: dec.reg_we = 1'b1;
      4'h2: begin
        dec.reg_we  = 1'b1;
        dec.use_imm = 1'b1;
      end
      4'h3: begin
        dec.reg_we    = 1'b1;
        dec.use_shamt = 1'b1;
      end
      default: begin
`ifdef HS32_DEC_FAULT_EN
        dec.fault = 1'b1;
`else
        dec.aluop = 3'd0;
`endif
      end
    endcase
  end

  // Both handshake flags come straight from the state register.
  assign in_ready  = (state_q != S_TWO);
  assign out_valid = (state_q != S_EMPTY);
  assign xfer_in   = in_valid & in_ready;
  assign xfer_out  = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    or_d    = or_q;
    sr_d    = sr_q;
    case (state_q)
      S_EMPTY: begin
        if (xfer_in) begin
          or_d    = dec;
          state_d = S_ONE;
        end
      end
      S_ONE: begin
        if (xfer_in && xfer_out) begin
          or_d = dec;
        end else if (xfer_in) begin
          sr_d    = dec;
          state_d = S_TWO;
        end else if (xfer_out) begin
          state_d = S_EMPTY;
        end
      end
      S_TWO: begin
        if (xfer_out) begin
          or_d    = sr_q;
          state_d = S_ONE;
        end
      end
      default: state_d = S_EMPTY;
    endcase
    // Flush discards everything, including any handshake in this cycle.
    if (flush) begin
      state_d = S_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_EMPTY;
      or_q    <= '0;
      sr_q    <= '0;
    end else begin
      state_q <= state_d;
      or_q    <= or_d;
      sr_q    <= sr_d;
    end
  end

  assign aluop     = or_q.aluop;
  assign rd        = or_q.rd;
  assign rm        = or_q.rm;
  assign rn        = or_q.rn;
  assign imm16     = or_q.imm16;
  assign imm5      = or_q.imm5;
  assign use_imm   = or_q.use_imm;
  assign use_shamt = or_q.use_shamt;
  assign reg_we    = or_q.reg_we;
  // Constant 0 unless HS32_DEC_FAULT_EN lets the decoder set it.
  assign fault     = or_q.fault;

endmodule

// File: tb/tb_hs32_decode.sv
// tb_hs32_decode: randomized and directed bench for hs32_decode.
//   The reference is a decode function plus a bounded queue (depth 2).
module tb_hs32_decode;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic        in_ready, out_valid;
  logic [31:0] in_instr;
  logic [2:0]  aluop;
  logic [3:0]  rd, rm, rn;
  logic [15:0] imm16, imm5;
  logic        use_imm, use_shamt, reg_we, fault;
  logic [50:0] act;

  int vectors = 0;
  int miscompares = 0;
  logic [50:0] mq[$];

  always #5 clk = ~clk;

  hs32_decode dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .aluop(aluop), .rd(rd), .rm(rm), .rn(rn), .imm16(imm16), .imm5(imm5),
    .use_imm(use_imm), .use_shamt(use_shamt), .reg_we(reg_we), .fault(fault)
  );

  assign act = {aluop, rd, rm, rn, imm16, imm5, use_imm, use_shamt, reg_we, fault};

  // Reference decode straight from the encoding table.
  function automatic logic [50:0] mdec(input logic [31:0] w);
    logic [2:0] op;
    logic ui, us, we, ft;
    op = w[27:25]; ui = 1'b0; us = 1'b0; we = 1'b0; ft = 1'b0;
    case (w[31:28])
      4'd0: op = 3'd0;
      4'd1: we = 1'b1;
      4'd2: begin we = 1'b1; ui = 1'b1; end
      4'd3: begin we = 1'b1; us = 1'b1; end
      default: begin
`ifdef HS32_DEC_FAULT_EN
        ft = 1'b1;
`else
        op = 3'd0;
`endif
      end
    endcase
    return {op, w[23:20], w[19:16], w[15:12], w[15:0], 11'b0, w[11:7], ui, us, we, ft};
  endfunction

  // Drive one cycle (called at negedge), update the queue model at the edge,
  // return at the following negedge.
  task automatic cyc(input logic v, input logic [31:0] w, input logic ordy, input logic fl);
    bit can_in, can_out;
    in_valid = v; in_instr = w; out_ready = ordy; flush = fl;
    can_in  = (mq.size() < 2);
    can_out = (mq.size() > 0);
    @(posedge clk);
    if (fl) mq.delete();
    else begin
      if (can_out && ordy) void'(mq.pop_front());
      if (can_in && v) mq.push_back(mdec(w));
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    in_valid = 1'b0; in_instr = '0; out_ready = 1'b0; flush = 1'b0; reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    cyc(1'b1, 32'h2A311234, 1'b0, 1'b0);
    // Reset while a word is held and another is offered.
    in_valid = 1'b1; in_instr = 32'h1FFFFFFF; reset = 1'b1;
    @(posedge clk); @(negedge clk);
    mq.delete();
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    vectors++;
    if (act !== 51'd0) begin miscompares++; $display("FAIL reset_fields got %h want 0", act); end
    reset = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_imm();
    cyc(1'b1, 32'h2A311234, 1'b1, 1'b0);
    vectors++;
    if (out_valid !== 1'b1) begin miscompares++; $display("FAIL imm_valid got %b want 1", out_valid); end
    vectors++;
    if ({aluop, rd, rm, imm16, use_imm, use_shamt, reg_we} !== {3'd5, 4'd3, 4'd1, 16'h1234, 1'b1, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL imm_fields got %h want aluop5 rd3 rm1 imm1234 ui1 us0 we1", act);
    end
  endtask

  task automatic test_shift();
    cyc(1'b1, 32'h34560380, 1'b1, 1'b0);
    vectors++;
    if ({out_valid, aluop, rd, rm, imm5, use_shamt, use_imm, reg_we} !== {1'b1, 3'd2, 4'd5, 4'd6, 16'h0007, 1'b1, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL shift_fields got v=%b %h want aluop2 rd5 rm6 imm5=7 us1", out_valid, act);
    end
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL shift_drain got %b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    logic [31:0] a, b, c;
    a = 32'h1123A000; b = 32'h2456BEEF; c = 32'h3789C080;
    cyc(1'b1, a, 1'b0, 1'b0);
    vectors++;
    if ({out_valid, in_ready, act} !== {1'b1, 1'b1, mdec(a)}) begin miscompares++; $display("FAIL bp_a got v%b r%b %h want A", out_valid, in_ready, act); end
    cyc(1'b1, b, 1'b0, 1'b0);
    vectors++;
    if ({in_ready, act} !== {1'b0, mdec(a)}) begin miscompares++; $display("FAIL bp_full got r%b %h want r0 A", in_ready, act); end
    cyc(1'b1, c, 1'b0, 1'b0);
    vectors++;
    if ({in_ready, act} !== {1'b0, mdec(a)}) begin miscompares++; $display("FAIL bp_hold got r%b %h want r0 A", in_ready, act); end
    cyc(1'b1, c, 1'b1, 1'b0);
    vectors++;
    if ({out_valid, in_ready, act} !== {1'b1, 1'b1, mdec(b)}) begin miscompares++; $display("FAIL bp_b got v%b r%b %h want B", out_valid, in_ready, act); end
    cyc(1'b1, c, 1'b1, 1'b0);
    vectors++;
    if ({out_valid, act} !== {1'b1, mdec(c)}) begin miscompares++; $display("FAIL bp_c got v%b %h want C", out_valid, act); end
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_drain got %b want 0", out_valid); end
  endtask

  task automatic test_stream();
    logic [31:0] w;
    for (int i = 0; i < 16; i++) begin
      w = {2'b00, $urandom_range(3, 0) > 1 ? 2'b11 : 2'b01, 28'($urandom)};
      w[29:28] = 2'($urandom_range(3, 0));
      cyc(1'b1, w, 1'b1, 1'b0);
      vectors++;
      if ({out_valid, in_ready, act} !== {1'b1, 1'b1, mdec(w)}) begin
        miscompares++;
        $display("FAIL stream[%0d] got v%b r%b %h want v1 r1 %h", i, out_valid, in_ready, act, mdec(w));
      end
    end
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic test_flush();
    cyc(1'b1, 32'h11111111, 1'b0, 1'b0);
    cyc(1'b1, 32'h12222222, 1'b0, 1'b0);
    cyc(1'b1, 32'h13333333, 1'b0, 1'b1);
    vectors++;
    if ({out_valid, in_ready} !== 2'b01) begin miscompares++; $display("FAIL flush_state got v%b r%b want v0 r1", out_valid, in_ready); end
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_leak got v%b %h want v0", out_valid, act); end
    // Flush from ONE with a word offered: the offered word must vanish too.
    cyc(1'b1, 32'h14444444, 1'b0, 1'b0);
    cyc(1'b1, 32'h15555555, 1'b1, 1'b1);
    vectors++;
    if ({out_valid, in_ready} !== 2'b01) begin miscompares++; $display("FAIL flush_one got v%b r%b want v0 r1", out_valid, in_ready); end
  endtask

  task automatic test_illegal();
    cyc(1'b1, 32'hF0000000, 1'b1, 1'b0);
`ifdef HS32_DEC_FAULT_EN
    vectors++;
    if ({out_valid, fault, reg_we, use_imm, use_shamt} !== 5'b11000) begin miscompares++; $display("FAIL illegal got v%b f%b we%b want fault1 we0", out_valid, fault, reg_we); end
`else
    vectors++;
    if ({out_valid, fault, aluop, reg_we, use_imm, use_shamt} !== {1'b1, 1'b0, 3'd0, 3'b000}) begin miscompares++; $display("FAIL illegal got v%b f%b op%0d we%b want NOP", out_valid, fault, aluop, reg_we); end
`endif
    cyc(1'b1, 32'h9EFFFFFF, 1'b1, 1'b0);
    vectors++;
    if (act !== mdec(32'h9EFFFFFF)) begin miscompares++; $display("FAIL illegal2 got %h want %h", act, mdec(32'h9EFFFFFF)); end
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      cyc(1'($urandom_range(3, 0) != 0), $urandom, 1'($urandom_range(2, 0) != 0),
          1'($urandom_range(15, 0) == 0));
      vectors++;
      if ({in_ready, out_valid} !== {mq.size() < 2, mq.size() > 0}) begin
        miscompares++;
        $display("FAIL rand_hs[%0d] got r%b v%b want depth %0d", i, in_ready, out_valid, mq.size());
      end
      if (mq.size() > 0) begin
        vectors++;
        if (act !== mq[0]) begin miscompares++; $display("FAIL rand_data[%0d] got %h want %h", i, act, mq[0]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_imm();
    test_shift();
    test_backpressure();
    test_stream();
    test_flush();
    test_illegal();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
